draw_text_status: RTL and testbench
===================================

// Module: draw_text_status
// PURPOSE
//  Reader side of the text-ROM interface: scans the VGA pixel stream and turns
//  each pixel position inside a text box into a character address (char_xy).
//  It reads back char_code, forms the font-ROM address, fetches the glyph row,
//  and overlays TEXT_COLOR on rgb_in. Sits in the VGA chain after the
//  background/game layers and before the output register.
// PARAMETERS
//  XPOS        11'd16   left edge of text box, pixels
//  YPOS        11'd16   top edge of text box, pixels
//  COLS        16       characters per row (max 16; char_xy[3:0])
//  ROWS        16       character rows (max 16; char_xy[7:4])
//  TEXT_COLOR  12'hFFF  RGB444 colour of set glyph pixels
// PORTS
//  pclk        in   1   pixel clock
//  rst_n       in   1   asynchronous reset, active low
//  hcount_in   in   11  horizontal pixel counter
//  vcount_in   in   11  vertical line counter
//  hsync_in    in   1   horizontal sync
//  vsync_in    in   1   vertical sync
//  hblnk_in    in   1   horizontal blanking
//  vblnk_in    in   1   vertical blanking
//  rgb_in      in   12  underlying pixel colour
//  char_xy     out  8   text-ROM address {row[3:0], col[3:0]}
//  char_code   in   7   text-ROM data (combinational, same cycle as char_xy)
//  font_addr   out  11  font-ROM address {char_code, glyph_row[3:0]}
//  font_pixels in   8   font-ROM row data, valid 1 pclk after font_addr (sync ROM)
//  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out
//              out  11/11/1/1/1/1  input timing delayed by exactly 3 pclk
//  rgb_out     out  12  composited pixel, aligned with the *_out timing
// BEHAVIOUR
//  - Reset (rst_n=0): every registered output, including char_xy, font_addr and
//    all pipeline stages, is 0. Reset mid-frame flushes the pipe. After release,
//    outputs are 0 until valid data has propagated (3 pclk), then track normally.
//  - in_box = hcount in [XPOS, XPOS+8*COLS) and vcount in [YPOS, YPOS+16*ROWS).
//    dx = hcount-XPOS, dy = vcount-YPOS (11-bit, evaluated only when in_box).
//  - S1 (reg): char_xy <= in_box ? {dy[7:4], dx[6:3]} : 8'h00.
//    Registers in_box, dy[3:0], dx[2:0] and the timing signals.
//  - S2 (reg): font_addr <= {char_code, dy1[3:0]}. Delays the flags.
//  - S3 (reg): font ROM returns font_pixels. bit = font_pixels[7 - dx[2:0]]
//    (MSB is the leftmost pixel).
//    rgb_out <= (hblnk|vblnk) ? 12'h000 : (in_box & bit) ? TEXT_COLOR : rgb_in.
//    rgb_in is delayed through the pipe so the base colour matches the same pixel.
//  - Latency: a fixed 3 pclk from any *_in to the matching *_out/rgb_out, with no
//    stalls and no handshake. The ROMs must meet their stated latency.
//  - Boundaries: hcount=XPOS+8*COLS-1 is inside and XPOS+8*COLS is outside; the
//    same rule applies vertically. A box clipped by the visible area needs no
//    special handling (blanking forces black). There is no state across
//    lines/frames beyond the pipe.
//  - Blank code " " (ROM default) renders as background through normal glyph
//    lookup; there is no special case.
// STRUCTURE
//  - Shared package vga_pkg: CHAR_W=8, CHAR_H=16, HCNT_W=11, RGB_W=12, and the
//    timing bundle widths.
//  - Sub-module: delay (params WIDTH, CLK_DEL; async active-low reset to 0) used
//    for the 3-stage timing/rgb shift. The text and font ROMs stay external to
//    this block.
// TESTING (bench: 800x600 timing gen, text ROM with "LEVEL" at 00..04,
//  behavioural sync font ROM where 'L' row 5 = 8'b1100_0000)
//  1 hcount=16,vcount=16 -> next pclk char_xy=8'h00; font_addr={"L",4'd0} 1 pclk later.
//  2 hcount=16,vcount=21,rgb_in=12'h00F -> 3 pclk later rgb_out=12'hFFF;
//    hcount=18 -> rgb_out=12'h00F.
//  3 hcount=16+8*16=144,vcount=16 -> rgb_out=rgb_in; hcount=143 -> char_xy=8'h0F.
//  4 hblnk=1 inside box on a set glyph pixel -> rgb_out=12'h000.
//  5 hcount=56,vcount=48 (col 5,row 2) -> char_xy=8'h25, space -> rgb_out=rgb_in.
//  6 rst_n low for 2 pclk mid-line -> all outputs 0 immediately; valid 3 pclk
//    after release, with hsync_out equal to hsync_in delayed by 3.

Source files
------------

// File: rtl/draw_text_status_pkg.sv
// Shared constants and helpers for the text overlay layer of the VGA chain.
// Character cell geometry, counter and colour widths, and glyph bit selection.
package draw_text_status_pkg;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int HCNT_W = 11;
  localparam int RGB_W  = 12;
  localparam int CODE_W = 7;
  localparam int XY_W   = 8;
  localparam int ROW_W  = 4;
  localparam int FONT_ADDR_W = CODE_W + ROW_W;
  localparam int TIMING_W = 2 * HCNT_W + 4;

  // MSB of a font row is the leftmost pixel of the cell.
  function automatic logic glyph_bit(input logic [CHAR_W-1:0] pixels,
                                     input logic [2:0] col);
    return pixels[3'd7 - col];
  endfunction

endpackage

// File: rtl/draw_text_status_if.sv
// Text-ROM / font-ROM bus between the text overlay layer and its two ROMs.
// The master drives addresses; the slave (ROM side) returns code and glyph row.
interface draw_text_status_if;
  import draw_text_status_pkg::*;

  logic [XY_W-1:0]        char_xy;
  logic [CODE_W-1:0]      char_code;
  logic [FONT_ADDR_W-1:0] font_addr;
  logic [CHAR_W-1:0]      font_pixels;

  modport master (
    output char_xy,
    output font_addr,
    input  char_code,
    input  font_pixels
  );

  modport slave (
    input  char_xy,
    input  font_addr,
    output char_code,
    output font_pixels
  );

endinterface

// File: rtl/draw_text_status_delay.sv
// Fixed-length shift register with asynchronous active-low clear.
// Used to carry VGA timing, base colour and pixel flags alongside the ROM fetches.
module draw_text_status_delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];
  logic [WIDTH-1:0] pipe_d [CLK_DEL];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CLK_DEL; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_text_status.sv
// Text overlay layer: maps box pixels to text-ROM cells, fetches glyph rows from
// a synchronous font ROM and paints TEXT_COLOR over rgb_in with 3 pclk latency.
module draw_text_status
  import draw_text_status_pkg::*;
#(
  parameter logic [HCNT_W-1:0] XPOS       = 11'd16,
  parameter logic [HCNT_W-1:0] YPOS       = 11'd16,
  parameter int                COLS       = 16,
  parameter int                ROWS       = 16,
  parameter logic [RGB_W-1:0]  TEXT_COLOR = 12'hFFF
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic [HCNT_W-1:0]   hcount_in,
  input  logic [HCNT_W-1:0]   vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblnk_in,
  input  logic                vblnk_in,
  input  logic [RGB_W-1:0]    rgb_in,
  draw_text_status_if.master  rom,
  output logic [HCNT_W-1:0]   hcount_out,
  output logic [HCNT_W-1:0]   vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblnk_out,
  output logic                vblnk_out,
  output logic [RGB_W-1:0]    rgb_out
);

  localparam logic [HCNT_W-1:0] X_END = XPOS + HCNT_W'(CHAR_W * COLS);
  localparam logic [HCNT_W-1:0] Y_END = YPOS + HCNT_W'(CHAR_H * ROWS);

  logic                   in_box;
  logic [6:0]             dx;
  logic [7:0]             dy;

  logic [XY_W-1:0]        char_xy_d, char_xy_q;
  logic                   in_box_p1_d, in_box_p1_q;
  logic [ROW_W-1:0]       dy_p1_d, dy_p1_q;
  logic [2:0]             dx_p1_d, dx_p1_q;
  logic [FONT_ADDR_W-1:0] font_addr_d, font_addr_q;

  logic                   in_box_p3;
  logic [2:0]             dx_p3;
  logic [RGB_W-1:0]       rgb_p3;

  // Stage 1: cell address from the raw counters.
  always_comb begin
    in_box = (hcount_in >= XPOS) && (hcount_in < X_END) &&
             (vcount_in >= YPOS) && (vcount_in < Y_END);
    dx = 7'(hcount_in - XPOS);
    dy = 8'(vcount_in - YPOS);
    char_xy_d   = in_box ? {dy[7:4], dx[6:3]} : '0;
    in_box_p1_d = in_box;
    dy_p1_d     = dy[3:0];
    dx_p1_d     = dx[2:0];
  end

  // Stage 2: text ROM answers combinationally; form the glyph-row address.
  always_comb begin
    font_addr_d = {rom.char_code, dy_p1_q};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy_q   <= '0;
      in_box_p1_q <= 1'b0;
      dy_p1_q     <= '0;
      dx_p1_q     <= '0;
      font_addr_q <= '0;
    end else begin
      char_xy_q   <= char_xy_d;
      in_box_p1_q <= in_box_p1_d;
      dy_p1_q     <= dy_p1_d;
      dx_p1_q     <= dx_p1_d;
      font_addr_q <= font_addr_d;
    end
  end

  assign rom.char_xy   = char_xy_q;
  assign rom.font_addr = font_addr_q;

  draw_text_status_delay #(
    .WIDTH   (TIMING_W + RGB_W),
    .CLK_DEL (3)
  ) u_timing_delay (
    .clk   (pclk),
    .rst_n (rst_n),
    .din   ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in}),
    .dout  ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_p3})
  );

  // Pixel flags ride two more stages so they meet the font ROM output.
  draw_text_status_delay #(
    .WIDTH   (4),
    .CLK_DEL (2)
  ) u_flag_delay (
    .clk   (pclk),
    .rst_n (rst_n),
    .din   ({in_box_p1_q, dx_p1_q}),
    .dout  ({in_box_p3, dx_p3})
  );

  // Stage 3: the font ROM output register is the final pipeline register;
  // compositing is a mux over stage-3 registers only.
  always_comb begin
    rgb_out = rgb_p3;
    if (hblnk_out || vblnk_out) begin
      rgb_out = '0;
    end else if (in_box_p3 && glyph_bit(rom.font_pixels, dx_p3)) begin
      rgb_out = TEXT_COLOR;
    end
  end

endmodule

// File: tb/tb_draw_text_status.sv
// Directed bench for draw_text_status with a "LEVEL" text ROM and a small
// synchronous font ROM; expected values are hand-computed per vector.
module tb_draw_text_status;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int checks = 0;
  int failures = 0;

  draw_text_status_if rom_if ();

  draw_text_status dut (
    .pclk       (clk),
    .rst_n      (rst_n),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .rom        (rom_if),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  always #5 clk = ~clk;

  // Text ROM: "LEVEL" at 00..04, space elsewhere.
  always_comb begin
    case (rom_if.char_xy)
      8'h00:   rom_if.char_code = 7'h4C;
      8'h01:   rom_if.char_code = 7'h45;
      8'h02:   rom_if.char_code = 7'h56;
      8'h03:   rom_if.char_code = 7'h45;
      8'h04:   rom_if.char_code = 7'h4C;
      default: rom_if.char_code = 7'h20;
    endcase
  end

  function automatic logic [7:0] glyph(input logic [10:0] addr);
    logic [6:0] c;
    logic [3:0] r;
    c = addr[10:4];
    r = addr[3:0];
    if (c == 7'h4C) begin
      if (r >= 4'd2 && r <= 4'd9) return 8'b1100_0000;
      if (r == 4'd10) return 8'b1111_1110;
    end
    return 8'h00;
  endfunction

  always @(posedge clk) rom_if.font_pixels <= glyph(rom_if.font_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic vb, input logic [11:0] rgb,
                         input logic [7:0] exp_xy, input logic [10:0] exp_fa,
                         input logic [11:0] exp_rgb);
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    hsync_in = 1'b0; vsync_in = 1'b0;
    step();
    check({tag, ".char_xy"}, 32'(rom_if.char_xy), 32'(exp_xy));
    step();
    check({tag, ".font_addr"}, 32'(rom_if.font_addr), 32'(exp_fa));
    step();
    check({tag, ".rgb_out"}, 32'(rgb_out), 32'(exp_rgb));
    check({tag, ".hcount_out"}, 32'(hcount_out), 32'(h));
  endtask

  logic [7:0] hs_pat;

  initial begin
    rst_n = 1'b0;
    hcount_in = 11'd50; vcount_in = 11'd30;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
    rgb_in = 12'hABC;
    step(); step();
    check("rst.char_xy", 32'(rom_if.char_xy), 0);
    check("rst.font_addr", 32'(rom_if.font_addr), 0);
    check("rst.rgb_out", 32'(rgb_out), 0);
    check("rst.hcount_out", 32'(hcount_out), 0);
    check("rst.hsync_out", 32'(hsync_out), 0);
    rst_n = 1'b1;

    run_vec("v1_corner",   11'd16,  11'd16,  0, 0, 12'h00F, 8'h00, 11'h4C0, 12'h00F);
    run_vec("v2_set",      11'd16,  11'd21,  0, 0, 12'h00F, 8'h00, 11'h4C5, 12'hFFF);
    run_vec("v2_clear",    11'd18,  11'd21,  0, 0, 12'h00F, 8'h00, 11'h4C5, 12'h00F);
    run_vec("v2_col1",     11'd17,  11'd21,  0, 0, 12'h00F, 8'h00, 11'h4C5, 12'hFFF);
    run_vec("v3_right_out",11'd144, 11'd16,  0, 0, 12'h0A5, 8'h00, 11'h4C0, 12'h0A5);
    run_vec("v3_right_in", 11'd143, 11'd16,  0, 0, 12'h0A5, 8'h0F, 11'h200, 12'h0A5);
    run_vec("v4_hblnk",    11'd16,  11'd21,  1, 0, 12'h00F, 8'h00, 11'h4C5, 12'h000);
    run_vec("v4_vblnk",    11'd17,  11'd21,  0, 1, 12'h00F, 8'h00, 11'h4C5, 12'h000);
    run_vec("v5_space",    11'd56,  11'd48,  0, 0, 12'h321, 8'h25, 11'h200, 12'h321);
    run_vec("v_col4_L",    11'd48,  11'd21,  0, 0, 12'h321, 8'h04, 11'h4C5, 12'hFFF);
    run_vec("v_bot_in",    11'd16,  11'd271, 0, 0, 12'h456, 8'hF0, 11'h20F, 12'h456);
    run_vec("v_bot_out",   11'd16,  11'd272, 0, 0, 12'h456, 8'h00, 11'h4C0, 12'h456);
    run_vec("v_left_out",  11'd15,  11'd21,  0, 0, 12'h456, 8'h00, 11'h4C5, 12'h456);

    // Mid-line reset: outputs clear immediately, then refill after 3 pclk.
    hcount_in = 11'd50; vcount_in = 11'd30; hsync_in = 1'b1; rgb_in = 12'h123;
    hblnk_in = 1'b0; vblnk_in = 1'b0;
    step(); step(); step();
    check("mid.pre_hcount", 32'(hcount_out), 32'd50);
    rst_n = 1'b0;
    #1;
    check("mid.rst_hcount", 32'(hcount_out), 0);
    check("mid.rst_rgb", 32'(rgb_out), 0);
    check("mid.rst_hsync", 32'(hsync_out), 0);
    check("mid.rst_char_xy", 32'(rom_if.char_xy), 0);
    check("mid.rst_font_addr", 32'(rom_if.font_addr), 0);
    step(); step();
    hs_pat = 8'b1011_0010;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      hcount_in = 11'(50 + k);
      hsync_in = hs_pat[k];
      step();
      if (k >= 2) begin
        check("rel.hsync", 32'(hsync_out), 32'(hs_pat[k-2]));
        check("rel.hcount", 32'(hcount_out), 32'(50 + k - 2));
      end else begin
        check("rel.hsync_zero", 32'(hsync_out), 0);
        check("rel.hcount_zero", 32'(hcount_out), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
